// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared state encoding, default sizes and width helpers for the fabric config loader
package fpga_cfg_pkg;

   typedef enum logic [2:0] {IDLE, PRE, LOAD, WRITE, POST, FFW, RDYW, DONE} state_t;

   localparam int CFG_W_DEF    = 224;
   localparam int N_FRAMES_DEF = 245;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cfg_wait_timer.sv
// cfg_wait_timer: loadable down-counter that parks at zero; done while the count is zero
module cfg_wait_timer #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);

   logic [W-1:0] cnt;

   // load a fresh count on state entry, otherwise run down to zero and hold
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= value;
      else if (cnt != '0) cnt <= cnt - 1'b1;

   assign done = (cnt == '0);

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: streams bitstream frames into the fabric config pins, then enables flops and signals rdy
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int CFG_W    = CFG_W_DEF,
   parameter int N_FRAMES = N_FRAMES_DEF,
   parameter int PRE_CYC  = 10,
   parameter int WR_CYC   = 1,
   parameter int POST_CYC = 10,
   parameter int FF_DLY   = 10,
   parameter int RDY_DLY  = 10,
   parameter int TIMEOUT  = 1024
) (
   input  logic                                clock,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                abort,
   input  logic [CFG_W-1:0]                    s_data,
   input  logic                                s_valid,
   output logic                                s_ready,
   output logic [CFG_W-1:0]                    configs_in,
   output logic [N_FRAMES-1:0]                 configs_en,
   output logic                                ff_en,
   output logic                                rdy,
   output logic                                busy,
   output logic                                err,
   output logic [clog2_min1(N_FRAMES)-1:0]     frame_idx
);

   localparam int IW = clog2_min1(N_FRAMES);
   localparam int TW = clog2_min1(imax(imax(imax(PRE_CYC, WR_CYC), imax(POST_CYC, FF_DLY)), RDY_DLY));
   localparam int SW = clog2_min1(TIMEOUT);

   // a zero-length wait state is bypassed by entering its successor directly
   localparam state_t RDYW_ENT = (RDY_DLY > 0) ? RDYW : DONE;
   localparam state_t FFW_ENT  = (FF_DLY > 0) ? FFW : RDYW_ENT;
   localparam state_t POST_ENT = (POST_CYC > 0) ? POST : FFW_ENT;
   localparam state_t PRE_ENT  = (PRE_CYC > 0) ? PRE : LOAD;

   state_t         state, state_nxt;
   logic [SW-1:0]  stall_cnt;
   logic [TW-1:0]  t_val;
   logic           t_load, t_done, stall_to, start_ok, last;

   // next-state logic; abort overrides every other transition
   always_comb begin
      state_nxt = state;
      stall_to  = (state == LOAD) && !s_valid && (stall_cnt == SW'(TIMEOUT - 1));
      start_ok  = start && !abort && (state == IDLE || state == DONE);
      last      = (frame_idx == IW'(N_FRAMES - 1));
      case (state)
         IDLE, DONE: if (start) state_nxt = PRE_ENT;
         PRE:        if (t_done) state_nxt = LOAD;
         LOAD:       state_nxt = s_valid ? WRITE : stall_to ? IDLE : LOAD;
         WRITE:      if (t_done) state_nxt = last ? POST_ENT : LOAD;
         POST:       if (t_done) state_nxt = FFW_ENT;
         FFW:        if (t_done) state_nxt = RDYW_ENT;
         RDYW:       if (t_done) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   // the shared timer is reloaded with (length-1) whenever a new state is entered
   assign t_load = (state_nxt != state);
   assign t_val  = (state_nxt == PRE)   ? TW'(PRE_CYC - 1)  :
                   (state_nxt == WRITE) ? TW'(WR_CYC - 1)   :
                   (state_nxt == POST)  ? TW'(POST_CYC - 1) :
                   (state_nxt == FFW)   ? TW'(FF_DLY - 1)   :
                   (state_nxt == RDYW)  ? TW'(RDY_DLY - 1)  : '0;

   cfg_wait_timer #(.W(TW)) u_timer (
      .clock (clock),
      .rst_n (rst_n),
      .load  (t_load),
      .value (t_val),
      .done  (t_done)
   );

   // state register
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   // frame index, captured frame, stall counter and sticky stall error
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) begin
         frame_idx  <= '0;
         configs_in <= '0;
         stall_cnt  <= '0;
         err        <= 1'b0;
      end else begin
         if (state_nxt == IDLE) frame_idx <= '0;
         else if (state == WRITE && t_done) frame_idx <= last ? '0 : frame_idx + 1'b1;
         if (s_valid && s_ready) configs_in <= s_data;
         stall_cnt <= (state == LOAD && !s_valid) ? stall_cnt + 1'b1 : '0;
         if (stall_to && !abort) err <= 1'b1;
         else if (start_ok) err <= 1'b0;
      end

   assign s_ready    = (state == LOAD);
   assign configs_en = (state == WRITE) ? (N_FRAMES'(1) << frame_idx) : '0;
   assign ff_en      = (state == RDYW) || (state == DONE);
   assign rdy        = (state == DONE);
   assign busy       = (state != IDLE) && (state != DONE);

endmodule
